// File: rtl/inta_sequencer.sv
// inta_sequencer
// Generates the two-pulse interrupt-acknowledge handshake of an 8080/8259
// style interrupt controller. When the synchronised INT line is high and the
// CPU interrupt-enable flag is set, inta_n is driven low twice: INTA_LOW clk
// cycles each, with INTA_GAP high cycles between them. The controller's data
// bus is sampled on the last edge of the second pulse. That byte is offered
// to the consumer through a valid/ready handshake. The block then waits for
// INT to drop, so that one INT assertion yields exactly one vector.
//
// Ports
//   clk        in   single clock, rising-edge active
//   reset_n    in   asynchronous active-low reset
//   int_req    in   INT from the interrupt controller (asynchronous to clk)
//   if_enable  in   CPU interrupt-enable flag, only sampled in IDLE
//   data_in    in   [7:0] controller data bus, captured at end of pulse 2
//   inta_n     out  registered active-low acknowledge strobe
//   vec_valid  out  captured vector available
//   vec_data   out  [7:0] captured vector, stable while vec_valid=1
//   vec_ready  in   consumer accepts the vector when vec_valid=1
//   busy       out  high whenever the FSM is not in IDLE
//
// Legal parameter range: INTA_LOW 1..15, INTA_GAP 1..15.

module inta_sequencer #(
  parameter int unsigned INTA_LOW = 2,
  parameter int unsigned INTA_GAP = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       int_req,
  input  logic       if_enable,
  input  logic [7:0] data_in,
  output logic       inta_n,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  input  logic       vec_ready,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PULSE1  = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_PULSE2  = 3'd3;
  localparam logic [2:0] S_DELIVER = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  // Counter reload values. Each phase lasts load+1 cycles, because the
  // phase-ending edge is the one on which the counter is already zero.
  localparam logic [3:0] LOW_LOAD = 4'(INTA_LOW - 1);
  localparam logic [3:0] GAP_LOAD = 4'(INTA_GAP - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       int_s;

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       inta_n_q, inta_n_d;
  logic       vec_valid_q, vec_valid_d;
  logic [7:0] vec_data_q, vec_data_d;

  // int_req is asynchronous to clk, so only this two-flop synchronised copy
  // is used internally. This is why a start can happen no earlier than the
  // third edge after INT rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= int_req;
      sync2_q <= sync1_q;
    end
  end

  assign int_s = sync2_q;

  // Next-state logic. inta_n is computed together with the state change, so
  // the registered strobe switches on the same edge that the FSM enters or
  // leaves a pulse. After IDLE, neither int_s nor if_enable is examined until
  // RELEASE. A sequence that has started therefore always runs to
  // completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inta_n_d    = inta_n_q;
    vec_valid_d = vec_valid_q;
    vec_data_d  = vec_data_q;

    case (state_q)
      S_IDLE: begin
        inta_n_d = 1'b1;
        if (int_s && if_enable) begin
          state_d  = S_PULSE1;
          cnt_d    = LOW_LOAD;
          inta_n_d = 1'b0;
        end
      end

      S_PULSE1: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_GAP;
          cnt_d    = GAP_LOAD;
          inta_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_PULSE2;
          cnt_d    = LOW_LOAD;
          inta_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_PULSE2: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_DELIVER;
          inta_n_d    = 1'b1;
          vec_valid_d = 1'b1;
          vec_data_d  = data_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DELIVER: begin
        if (vec_ready) begin
          state_d     = S_RELEASE;
          vec_valid_d = 1'b0;
        end
      end

      S_RELEASE: begin
        if (!int_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cnt_d       = 4'd0;
        inta_n_d    = 1'b1;
        vec_valid_d = 1'b0;
      end
    endcase
  end

  // State registers. Reset is asynchronous, so that a reset in the middle of
  // a pulse releases inta_n immediately and drops any vector that is not yet
  // complete.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      inta_n_q    <= 1'b1;
      vec_valid_q <= 1'b0;
      vec_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inta_n_q    <= inta_n_d;
      vec_valid_q <= vec_valid_d;
      vec_data_q  <= vec_data_d;
    end
  end

  assign inta_n    = inta_n_q;
  assign vec_valid = vec_valid_q;
  assign vec_data  = vec_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer
// Drives two instances of inta_sequencer with the same stimulus:
//   u_dut0  default timing (INTA_LOW=2, INTA_GAP=2)
//   u_dut1  INTA_LOW=1, INTA_GAP=3
// A timeline model predicts each instance's outputs. It counts edges since
// the start of a sequence and derives the inta_n level from the pulse and gap
// widths. Outputs are compared on every falling clock edge. Literal
// waveforms and counts, worked out by hand, pin the model as well.

module tb_inta_sequencer;

  localparam int MP_IDLE    = 0;
  localparam int MP_ACTIVE  = 1;
  localparam int MP_DELIVER = 2;
  localparam int MP_RELEASE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       int_req;
  logic       if_enable;
  logic [7:0] data_in;
  logic       vec_ready;

  logic [1:0]      intaN;
  logic [1:0]      vecValid;
  logic [1:0][7:0] vecData;
  logic [1:0]      busy;

  int compared   = 0;
  int mismatched = 0;
  logic checkEn  = 1'b0;

  inta_sequencer u_dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .int_req   (int_req),
    .if_enable (if_enable),
    .data_in   (data_in),
    .inta_n    (intaN[0]),
    .vec_valid (vecValid[0]),
    .vec_data  (vecData[0]),
    .vec_ready (vec_ready),
    .busy      (busy[0])
  );

  inta_sequencer #(.INTA_LOW(1), .INTA_GAP(3)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .int_req   (int_req),
    .if_enable (if_enable),
    .data_in   (data_in),
    .inta_n    (intaN[1]),
    .vec_valid (vecValid[1]),
    .vec_data  (vecData[1]),
    .vec_ready (vec_ready),
    .busy      (busy[1])
  );

  // Timeline model: a sequence is a window of 2*LOW+GAP edges after the
  // start edge. inta_n is low during the first LOW and the last LOW of that
  // window. The capture happens on the edge that closes the window.
  int modelLow [2] = '{2, 1};
  int modelGap [2] = '{3 - 1, 3};
  int phase    [2];
  int elapsed  [2];
  logic            mS1, mS2, mInts;
  logic [1:0]      expInta;
  logic [1:0]      expValid;
  logic [1:0][7:0] expData;
  logic [1:0]      expBusy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mS1 = 1'b0;
      mS2 = 1'b0;
      for (int k = 0; k < 2; k++) begin
        phase[k]    = MP_IDLE;
        elapsed[k]  = 0;
        expValid[k] = 1'b0;
        expData[k]  = 8'h00;
      end
    end else begin
      mInts = mS2;
      mS2   = mS1;
      mS1   = int_req;
      for (int k = 0; k < 2; k++) begin
        case (phase[k])
          MP_IDLE: begin
            if (mInts && if_enable) begin
              phase[k]   = MP_ACTIVE;
              elapsed[k] = 0;
            end
          end
          MP_ACTIVE: begin
            elapsed[k] = elapsed[k] + 1;
            if (elapsed[k] == 2 * modelLow[k] + modelGap[k]) begin
              phase[k]    = MP_DELIVER;
              expValid[k] = 1'b1;
              expData[k]  = data_in;
            end
          end
          MP_DELIVER: begin
            if (vec_ready) begin
              phase[k]    = MP_RELEASE;
              expValid[k] = 1'b0;
            end
          end
          default: begin
            if (!mInts) phase[k] = MP_IDLE;
          end
        endcase
      end
    end
    for (int k = 0; k < 2; k++) begin
      expInta[k] = !(phase[k] == MP_ACTIVE &&
                     (elapsed[k] < modelLow[k] ||
                      elapsed[k] >= modelLow[k] + modelGap[k]));
      expBusy[k] = (phase[k] != MP_IDLE);
    end
  end

  // Records the vectors the DUTs hand over. Sampling on the rising edge
  // reads the values that are present just before the handshake edge.
  int         dutCount [2] = '{0, 0};
  logic [7:0] dutLast  [2] = '{8'h00, 8'h00};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset_n && vecValid[k] && vec_ready) begin
        dutCount[k] = dutCount[k] + 1;
        dutLast[k]  = vecData[k];
      end
    end
  end

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t",
               name, k, act, exp, $time);
    end
  endtask

  // Compares every output of both instances against the model on each
  // falling edge, so no clock edge goes unchecked.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput("m_inta_n", k, 32'(intaN[k]), 32'(expInta[k]));
        checkOutput("m_vec_valid", k, 32'(vecValid[k]), 32'(expValid[k]));
        checkOutput("m_vec_data", k, 32'(vecData[k]), 32'(expData[k]));
        checkOutput("m_busy", k, 32'(busy[k]), 32'(expBusy[k]));
      end
    end
  end

  task automatic applyStimulus(input logic ir, input logic ie,
                               input logic [7:0] d, input logic rdy);
    int_req   = ir;
    if_enable = ie;
    data_in   = d;
    vec_ready = rdy;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Ticks until dut0's inta_n (sel=0) or vec_valid (sel=1) reaches lvl.
  // If the budget runs out, this counts as a failed comparison.
  task automatic waitLevel(input string name, input int sel,
                           input logic lvl, input int budget);
    int   n;
    logic cur;
    n   = 0;
    cur = (sel == 0) ? intaN[0] : vecValid[0];
    while (cur !== lvl && n < budget) begin
      tick(1);
      n   = n + 1;
      cur = (sel == 0) ? intaN[0] : vecValid[0];
    end
    if (cur !== lvl) begin
      compared   = compared + 1;
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: timeout, got %0b expected %0b", name, cur, lvl);
    end
  endtask

  logic [9:0] intaPat [2];
  logic [9:0] validPat [2];

  initial begin
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2 checkEn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_inta_n", k, 32'(intaN[k]), 32'd1);
      checkOutput("rst_vec_valid", k, 32'(vecValid[k]), 32'd0);
      checkOutput("rst_vec_data", k, 32'(vecData[k]), 32'h00);
      checkOutput("rst_busy", k, 32'(busy[k]), 32'd0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick(2);

    // Basic sequence. The data bus shows 8'h11 early and 8'h48 from edge 7
    // on. Edges 1-2 fill the synchroniser and edge 3 starts the sequence.
    $display("[TB] basic sequence");
    applyStimulus(1'b1, 1'b1, 8'h11, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      for (int k = 0; k < 2; k++) begin
        intaPat[k][9 - i]  = intaN[k];
        validPat[k][9 - i] = vecValid[k];
      end
      if (i == 5) data_in = 8'h48;
    end
    checkOutput("basic_inta_wave", 0, 32'(intaPat[0]), 32'b1100110011);
    checkOutput("basic_valid_wave", 0, 32'(validPat[0]), 32'b0000000010);
    checkOutput("sweep_inta_wave", 1, 32'(intaPat[1]), 32'b1101110111);
    checkOutput("sweep_valid_wave", 1, 32'(validPat[1]), 32'b0000000100);
    for (int k = 0; k < 2; k++) begin
      checkOutput("basic_vec", k, 32'(dutLast[k]), 32'h48);
      checkOutput("basic_busy_held", k, 32'(busy[k]), 32'd1);
    end
    int_req = 1'b0;
    tick(4);
    for (int k = 0; k < 2; k++)
      checkOutput("basic_busy_released", k, 32'(busy[k]), 32'd0);

    // Back-pressure: the consumer holds off for five edges after capture.
    $display("[TB] back-pressure");
    applyStimulus(1'b1, 1'b1, 8'h48, 1'b0);
    waitLevel("bp_capture", 1, 1'b1, 20);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("bp_valid_held", 0, 32'(vecValid[0]), 32'd1);
      checkOutput("bp_data_held", 0, 32'(vecData[0]), 32'h48);
    end
    vec_ready = 1'b1;
    tick(1);
    checkOutput("bp_handshake", 0, 32'(vecValid[0]), 32'd0);
    int_req = 1'b0;
    tick(4);

    // Masked start. if_enable is dropped again right after the start, and
    // that must not disturb the sequence in progress.
    $display("[TB] masked start");
    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      for (int k = 0; k < 2; k++) begin
        checkOutput("mask_inta_n", k, 32'(intaN[k]), 32'd1);
        checkOutput("mask_busy", k, 32'(busy[k]), 32'd0);
      end
    end
    if_enable = 1'b1;
    tick(1);
    for (int k = 0; k < 2; k++)
      checkOutput("mask_first_fall", k, 32'(intaN[k]), 32'd0);
    if_enable = 1'b0;
    tick(10);
    int_req = 1'b0;
    tick(4);
    for (int k = 0; k < 2; k++)
      checkOutput("mask_vec", k, 32'(dutLast[k]), 32'h5A);

    // INT drops during the first pulse. The sequence still completes and
    // delivers the spurious vector.
    $display("[TB] INT drop");
    applyStimulus(1'b1, 1'b1, 8'h4F, 1'b1);
    waitLevel("drop_start", 0, 1'b0, 20);
    int_req = 1'b0;
    tick(12);
    for (int k = 0; k < 2; k++) begin
      checkOutput("drop_vec", k, 32'(dutLast[k]), 32'h4F);
      checkOutput("drop_count", k, 32'(dutCount[k]), 32'd4);
      checkOutput("drop_idle", k, 32'(busy[k]), 32'd0);
    end

    // Reset during dut0's second pulse. With INT still held, the synchroniser
    // must refill before a fresh sequence starts on the third edge.
    $display("[TB] reset mid-pulse");
    applyStimulus(1'b1, 1'b1, 8'h33, 1'b1);
    waitLevel("rst_p1", 0, 1'b0, 20);
    waitLevel("rst_gap", 0, 1'b1, 20);
    waitLevel("rst_p2", 0, 1'b0, 20);
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("async_inta_n", k, 32'(intaN[k]), 32'd1);
      checkOutput("async_vec_valid", k, 32'(vecValid[k]), 32'd0);
      checkOutput("async_vec_data", k, 32'(vecData[k]), 32'h00);
      checkOutput("async_busy", k, 32'(busy[k]), 32'd0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    checkOutput("post_rst_e1", 0, 32'(intaN[0]), 32'd1);
    tick(1);
    checkOutput("post_rst_e2", 0, 32'(intaN[0]), 32'd1);
    tick(1);
    checkOutput("post_rst_e3", 0, 32'(intaN[0]), 32'd0);
    tick(10);
    int_req = 1'b0;
    tick(4);

    // Five INT assertions delivered vectors (the aborted one delivers none),
    // so each instance must report exactly five.
    for (int k = 0; k < 2; k++) begin
      checkOutput("total_vectors", k, 32'(dutCount[k]), 32'd5);
      checkOutput("final_vec", k, 32'(dutLast[k]), 32'h33);
    end

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 The block SHALL have parameter INTA_LOW, default 2, giving the number of clk cycles each INTA pulse is held low (legal range 1..15).
REQ-002 The block SHALL have parameter INTA_GAP, default 2, giving the number of clk cycles inta_n is high between the two pulses (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port int_req, input, 1 bit: INT line from the interrupt controller, asynchronous to clk.
REQ-006 The block SHALL have port if_enable, input, 1 bit: CPU interrupt-enable flag; a new sequence starts only when it is 1.
REQ-007 The block SHALL have port data_in, input, 8 bits: controller data bus carrying the vector during the second pulse.
REQ-008 The block SHALL have port inta_n, output, 1 bit: active-low interrupt-acknowledge strobe, registered.
REQ-009 The block SHALL have port vec_valid, output, 1 bit: a captured vector is available.
REQ-010 The block SHALL have port vec_data, output, 8 bits: the captured vector, stable while vec_valid=1.
REQ-011 The block SHALL have port vec_ready, input, 1 bit: consumer accepts the vector when vec_valid=1 and vec_ready=1 on the same edge.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 int_req SHALL pass through a two-flop synchronizer; only the synchronized value, int_s, is used internally.
REQ-014 The FSM SHALL have states IDLE, PULSE1, GAP, PULSE2, DELIVER, and RELEASE, plus a 4-bit down-counter cnt.
REQ-015 IDLE -> PULSE1 SHALL occur on an edge where int_s=1 and if_enable=1, loading cnt=INTA_LOW-1; inta_n is 0 from that edge on.
REQ-016 PULSE1 SHALL decrement cnt each edge; at cnt=0 it goes to GAP, loading cnt=INTA_GAP-1, and inta_n returns to 1.
REQ-017 GAP SHALL decrement cnt; at cnt=0 it goes to PULSE2, loading cnt=INTA_LOW-1, and inta_n goes to 0.
REQ-018 PULSE2 SHALL decrement cnt; at cnt=0 it captures data_in into vec_data, sets vec_valid=1, sets inta_n=1, and goes to DELIVER.
REQ-019 Total inta_n low time per sequence SHALL be exactly 2*INTA_LOW cycles, with exactly INTA_GAP high cycles between the two pulses.
REQ-020 DELIVER SHALL hold vec_valid=1 and vec_data constant until the handshake edge, then clear vec_valid and go to RELEASE.
REQ-021 RELEASE SHALL wait for int_s=0 before going to IDLE, so one INT assertion yields exactly one sequence.
REQ-022 If int_s drops during PULSE1, GAP, or PULSE2, the sequence SHALL still complete both pulses and deliver whatever data_in holds at capture.
REQ-023 Changes of if_enable after leaving IDLE SHALL NOT affect the sequence in progress.
REQ-024 In IDLE, int_s=1 with if_enable=0 SHALL keep the FSM in IDLE with inta_n=1; the sequence starts on the first edge where if_enable becomes 1 while int_s is still 1.
REQ-025 vec_ready while vec_valid=0 SHALL be ignored.
REQ-026 vec_data SHALL change only at the capture edge of REQ-018.

Reset
REQ-027 reset_n=0 SHALL immediately, without waiting for a clock edge, force the following: state=IDLE, cnt=0, synchronizer flops=0, inta_n=1, vec_valid=0, vec_data=8'h00, busy=0.
REQ-028 Reset asserted mid-pulse SHALL return inta_n to 1 without waiting for clk, and no partial vector SHALL be delivered.
REQ-029 After reset_n rises, the first sequence SHALL start no earlier than the third rising edge, because of synchronizer latency.

Verification
REQ-030 Basic sequence (defaults): int_req=1, if_enable=1, data_in=8'h48 during PULSE2, vec_ready=1 -> inta_n low for 2 cycles, high for 2, low for 2; vec_valid pulses for one cycle with vec_data=8'h48; busy returns to 0 only after int_req=0.
REQ-031 Back-pressure: vec_ready=0 for 5 cycles after capture -> vec_valid stays 1 and vec_data stays 8'h48 for those 5 cycles; the handshake occurs on the 6th edge.
REQ-032 Masked start: int_req=1 with if_enable=0 for 10 cycles, then if_enable=1 -> no inta_n activity during masking; the first inta_n falling edge occurs one edge after if_enable rises.
REQ-033 INT drop: int_req deasserted during PULSE1 -> both pulses still occur and the spurious vector 8'h4F on data_in is delivered.
REQ-034 Reset mid-PULSE2: reset_n=0 -> inta_n=1 and vec_valid=0 asynchronously; after release with int_req held 1, a fresh full two-pulse sequence runs.
REQ-035 Parameter sweep INTA_LOW=1, INTA_GAP=3 -> pulse widths 1/3/1 cycles; no INT assertion ever produces more than one vector.
